filter_output_sink: RTL and testbench

- Receive end of the IIR filter datapath. Consumes the filter's 64-bit signed output once per sample.
- Requantizes each output to 8-bit signed with round-half-up and saturation, then buffers the samples in a small FIFO.
- A downstream consumer (DAC serializer or capture logic) drains the FIFO through a valid/ready handshake.
- Forms the hardware counterpart to the 8-bit sample stream that feeds the filter input.

---
 rtl/filter_output_sink.sv | 139 +++++++++++++
 tb/tb_filter_output_sink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_output_sink.sv
// Receive end of the IIR datapath: requantizes each 64-bit filter output to a
// saturated 8-bit sample and buffers it in a show-ahead FIFO for a valid/ready consumer.
module filter_output_sink #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic [IN_W-1:0]            data_in,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic [15:0]                sat_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // Requantizer constants on IN_W+1 bits so adding the rounding half never wraps.
  localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1) << (FRAC-1);
  localparam logic signed [IN_W:0] MAX_R = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MIN_R = ~MAX_R;

  // Pipeline state
  logic              s1_vld_q, s1_vld_d;
  logic [IN_W-1:0]   s1_data_q;
  logic              s2_vld_q, s2_vld_d;
  logic [OUT_W-1:0]  s2_data_q;
  logic              s2_sat_q;

  // FIFO state
  logic [OUT_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       sat_q, sat_d;

  // Requantization of the S1 register
  logic signed [IN_W:0] ext_s;
  logic signed [IN_W:0] rnd_s;
  logic [OUT_W-1:0]     q_res;
  logic                 q_sat;

  always_comb begin
    ext_s = {s1_data_q[IN_W-1], s1_data_q};
    rnd_s = (ext_s + HALF) >>> FRAC;
    q_res = rnd_s[OUT_W-1:0];
    q_sat = 1'b0;
    if (rnd_s > MAX_R) begin
      q_res = {1'b0, {(OUT_W-1){1'b1}}};
      q_sat = 1'b1;
    end else if (rnd_s < MIN_R) begin
      q_res = {1'b1, {(OUT_W-1){1'b0}}};
      q_sat = 1'b1;
    end
  end

  // FIFO control; a push into a full FIFO is accepted only when a pop frees a slot.
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pop      = (count_q != '0) && out_ready;
    push     = s2_vld_q && (!full || pop);
    drop     = s2_vld_q && full && !pop;

    s1_vld_d = sample_en;
    s2_vld_d = s1_vld_q;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d    = ovf_q | drop;

    sat_d    = sat_q;
    if (s2_vld_q && s2_sat_q && (sat_q != '1)) begin
      sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sat_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (sample_en) begin
      s1_data_q <= data_in;
    end
    if (s1_vld_q) begin
      s2_data_q <= q_res;
      s2_sat_q  <= q_sat;
    end
    if (rst && push) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  always_comb begin
    out_valid  = (count_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    fifo_count = count_q;
    overflow   = ovf_q;
    sat_count  = sat_q;
  end

endmodule

// File: tb/tb_filter_output_sink.sv
// Bench for filter_output_sink: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_filter_output_sink;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_en = 1'b0;
  logic [63:0] data_in = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  filter_output_sink #(.IN_W(64), .OUT_W(8), .FRAC(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Reference model: samples in flight with the cycle they reach the buffer, plus the buffer itself.
  typedef struct {
    int         due;
    logic [7:0] v;
    bit         s;
  } pend_t;

  pend_t      pq[$];
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_sat = 0;
  int         cyc = 0;

  function automatic void requant(input logic [63:0] x, output logic [7:0] v, output bit s);
    logic signed [127:0] w;
    logic signed [127:0] q;
    w = {{64{x[63]}}, x};
    w = w + 128'sd32768;
    q = w / 128'sd65536;
    if (w < 0 && q * 128'sd65536 != w) q = q - 128'sd1;
    if (q > 128'sd127) begin
      v = 8'h7F; s = 1'b1;
    end else if (q < -128'sd128) begin
      v = 8'h80; s = 1'b1;
    end else begin
      v = q[7:0]; s = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    pend_t      p;
    bit         pop;
    logic [7:0] v;
    bit         s;
    if (!rst) begin
      pq.delete();
      mq.delete();
      m_ovf = 1'b0;
      m_sat = 0;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        if (p.s && m_sat < 65535) m_sat++;
        if (mq.size() < DEPTH) mq.push_back(p.v);
        else m_ovf = 1'b1;
      end
      if (sample_en) begin
        requant(data_in, v, s);
        pq.push_back('{due: cyc + 2, v: v, s: s});
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", out_valid, mq.size() != 0);
    chk("model_data", out_data, (mq.size() != 0) ? mq[0] : 8'h00);
    chk("model_count", fifo_count, mq.size());
    chk("model_ovf", overflow, m_ovf);
    chk("model_sat", sat_count, m_sat);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      sample_en = 1'($urandom);
      out_ready = 1'($urandom);
      data_in   = {$urandom, $urandom};
      step();
    end
    rst = 1'b1;
    sample_en = 1'b0;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] din;
    logic [7:0]  exp;
    logic [15:0] sat;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{64'h0000_0000_0005_8000, 8'h06, 16'd0};
    vt[1]  = '{64'hFFFF_FFFF_FFFD_8000, 8'hFE, 16'd0};
    vt[2]  = '{64'hFFFF_FFFF_FFFF_0000, 8'hFF, 16'd0};
    vt[3]  = '{64'h0000_0000_0000_7FFF, 8'h00, 16'd0};
    vt[4]  = '{64'h0000_0000_0000_8000, 8'h01, 16'd0};
    vt[5]  = '{64'h0000_0000_0100_0000, 8'h7F, 16'd1};
    vt[6]  = '{64'h0000_0000_007F_8000, 8'h7F, 16'd2};
    vt[7]  = '{64'hFFFF_FFFF_FF00_0000, 8'h80, 16'd3};
    vt[8]  = '{64'h0000_0000_007F_7FFF, 8'h7F, 16'd3};
    vt[9]  = '{64'hFFFF_FFFF_FF7F_8000, 8'h80, 16'd3};
    vt[10] = '{64'hFFFF_FFFF_FF7F_7FFF, 8'h80, 16'd4};
    vt[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 8'h7F, 16'd5};
    vt[12] = '{64'h8000_0000_0000_0000, 8'h80, 16'd6};
    vt[13] = '{64'hFFFF_FFFF_FFFF_7FFF, 8'hFF, 16'd6};
    vt[14] = '{64'hFFFF_FFFF_FFFF_8000, 8'h00, 16'd6};
    vt[15] = '{64'h0000_0000_0000_0000, 8'h00, 16'd6};

    // Reset state
    do_reset(2);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_count", fifo_count, 4'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_sat", sat_count, 16'd0);

    // Single-sample vectors: latency, rounding and clamping
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b0;
      sample_en = 1'b1;
      data_in   = vt[i].din;
      step();
      sample_en = 1'b0;
      data_in   = {$urandom, $urandom};
      step();
      chk("vec_early_valid", out_valid, 1'b0);
      step();
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_data", out_data, vt[i].exp);
      chk("vec_count", fifo_count, 4'd1);
      chk("vec_sat", sat_count, vt[i].sat);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("vec_drained_valid", out_valid, 1'b0);
      chk("vec_drained_data", out_data, 8'h00);
    end

    // Fill past capacity, then drain in order
    do_reset(2);
    for (int k = 1; k <= 9; k++) begin
      sample_en = 1'b1;
      data_in   = 64'(k) << 16;
      step();
    end
    sample_en = 1'b0;
    step();
    step();
    chk("full_count", fifo_count, 4'd8);
    chk("full_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_data", out_data, 8'(k));
      step();
    end
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_data_empty", out_data, 8'h00);
    chk("drain_ovf_sticky", overflow, 1'b1);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    do_reset(2);
    for (int e = 0; e < 14; e++) begin
      sample_en = (e < 12);
      data_in   = 64'(e + 1) << 16;
      out_ready = (e >= 10);
      step();
      if (e >= 9) begin
        chk("simul_count", fifo_count, 4'd8);
        chk("simul_ovf", overflow, 1'b0);
        chk("simul_order", out_data, 8'(e - 8));
      end
    end
    sample_en = 1'b0;
    out_ready = 1'b1;
    for (int k = 5; k <= 12; k++) begin
      chk("simul_drain", out_data, 8'(k));
      step();
    end
    chk("simul_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset with buffered and in-flight samples
    do_reset(2);
    for (int k = 1; k <= 7; k++) begin
      sample_en = 1'b1;
      data_in   = (64'(k) << 16) + 64'h3000;
      step();
    end
    chk("midrst_pre_count", fifo_count, 4'd5);
    rst = 1'b0;
    data_in = 64'h0000_0000_0100_0000;
    step();
    chk("midrst_count", fifo_count, 4'd0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 8'h00);
    rst = 1'b1;
    sample_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_late_write", fifo_count, 4'd0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      int unsigned pe;
      int unsigned pr;
      pe = (i / 150) % 2 == 0 ? 80 : 40;
      pr = (i / 150) % 2 == 0 ? 30 : 85;
      rst       = ($urandom_range(0, 199) != 0);
      sample_en = ($urandom_range(0, 99) < pe);
      out_ready = ($urandom_range(0, 99) < pr);
      case ($urandom_range(0, 3))
        0: data_in = {$urandom, $urandom};
        1: data_in = 64'(longint'($urandom_range(0, 300 * 65536)) - longint'(150 * 65536));
        2: data_in = 64'(longint'($urandom_range(0, 65536)) - 64'sd32768) + (64'(longint'($urandom_range(0, 4))) << 16);
        default: data_in = {{48{1'b0}}, 16'($urandom)} + 64'h007F_0000;
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
